// File: rtl/ddr2_rd_pkg.sv
// Shared types and constants for the DDR2 read-data user FIFO stage.
package ddr2_rd_pkg;

    localparam int unsigned DEF_DATA_WIDTH  = 32;
    localparam int unsigned DEF_BURST_BEATS = 2;

    typedef enum logic {
        WAIT_CAL = 1'b0,
        RUN      = 1'b1
    } rd_state_e;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ddr2_rd_user_fifo_if.sv
// Read-beat input and user-side handshake bundle for ddr2_rd_user_fifo.
interface ddr2_rd_user_fifo_if
    import ddr2_rd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = 16
);
    localparam int unsigned CNT_W = cnt_w(FIFO_DEPTH);

    logic                    comp_done;
    logic                    read_data_valid;
    logic [DATA_WIDTH-1:0]   read_data_fifo_rise;
    logic [DATA_WIDTH-1:0]   read_data_fifo_fall;
    logic [2*DATA_WIDTH-1:0] user_rd_data;
    logic                    user_rd_valid;
    logic                    user_rd_ready;
    logic                    user_rd_last;
    logic [CNT_W-1:0]        fifo_count;
    logic                    rd_cmd_allow;
    logic                    overflow;

    modport slave (
        input  comp_done, read_data_valid, read_data_fifo_rise, read_data_fifo_fall,
        input  user_rd_ready,
        output user_rd_data, user_rd_valid, user_rd_last, fifo_count, rd_cmd_allow, overflow
    );

    modport master (
        output comp_done, read_data_valid, read_data_fifo_rise, read_data_fifo_fall,
        output user_rd_ready,
        input  user_rd_data, user_rd_valid, user_rd_last, fifo_count, rd_cmd_allow, overflow
    );

endinterface

// File: rtl/ddr2_sync_fifo.sv
// First-word-fall-through FIFO; head word, valid and count are all registered,
// so a push into an empty FIFO becomes visible one cycle later.
module ddr2_sync_fifo
    import ddr2_rd_pkg::*;
#(
    parameter  int unsigned WIDTH = 65,
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned CNT_W = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             ready_i,
    output logic             accept_c,
    output logic [CNT_W-1:0] count_next_c,
    output logic [WIDTH-1:0] dout_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             pop_c;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        pop_c    = valid_q && ready_i;
        accept_c = push_i && ((count_q < CNT_W'(DEPTH)) || pop_c);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (accept_c) begin
            mem_d[wr_ptr_q] = din_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d      = count_q + CNT_W'(accept_c) - CNT_W'(pop_c);
        valid_d      = (count_d != '0);
        data_d       = valid_d ? mem_d[rd_ptr_d] : '0;
        count_next_c = count_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    assign dout_o  = data_q;
    assign valid_o = valid_q;
    assign count_o = count_q;

endmodule

// File: rtl/ddr2_rd_user_fifo.sv
// Gates read beats on calibration, packs rise/fall pairs with a burst-last tag
// into the user FIFO, and issues read-command credit when a whole burst fits.
module ddr2_rd_user_fifo
    import ddr2_rd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned BURST_BEATS = DEF_BURST_BEATS
) (
    input logic                clk,
    input logic                reset,
    ddr2_rd_user_fifo_if.slave bus
);
    localparam int unsigned WORD_W = 2 * DATA_WIDTH + 1;
    localparam int unsigned CNT_W  = cnt_w(FIFO_DEPTH);
    localparam int unsigned BEAT_W = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
    localparam int unsigned CREDIT = 2 * BURST_BEATS;

    rd_state_e         state_q, state_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic              overflow_q, overflow_d;
    logic              rd_cmd_allow_q, rd_cmd_allow_d;
    logic              push_c, last_c, accept_c;
    logic [CNT_W-1:0]  count_next_c, count_o;
    logic [WORD_W-1:0] din_c, head_o;
    logic              head_valid_o;

    // Beat counter keeps advancing on dropped beats so last tags stay burst-aligned.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        overflow_d = overflow_q;
        push_c     = 1'b0;
        last_c     = (beat_cnt_q == BEAT_W'(BURST_BEATS - 1));
        unique case (state_q)
            WAIT_CAL: begin
                beat_cnt_d = '0;
                if (bus.comp_done) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.read_data_valid) begin
                    push_c     = 1'b1;
                    beat_cnt_d = last_c ? '0 : beat_cnt_q + BEAT_W'(1);
                end
                if (!bus.comp_done) begin
                    state_d    = WAIT_CAL;
                    beat_cnt_d = '0;
                end
            end
        endcase
        if (push_c && !accept_c) begin
            overflow_d = 1'b1;
        end
        rd_cmd_allow_d = (state_d == RUN) &&
                         ((CNT_W'(FIFO_DEPTH) - count_next_c) >= CNT_W'(CREDIT));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= WAIT_CAL;
            beat_cnt_q     <= '0;
            overflow_q     <= 1'b0;
            rd_cmd_allow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            beat_cnt_q     <= beat_cnt_d;
            overflow_q     <= overflow_d;
            rd_cmd_allow_q <= rd_cmd_allow_d;
        end
    end

    assign din_c = {last_c, bus.read_data_fifo_fall, bus.read_data_fifo_rise};

    ddr2_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (reset),
        .push_i       (push_c),
        .din_i        (din_c),
        .ready_i      (bus.user_rd_ready),
        .accept_c     (accept_c),
        .count_next_c (count_next_c),
        .dout_o       (head_o),
        .valid_o      (head_valid_o),
        .count_o      (count_o)
    );

    assign bus.user_rd_data  = head_o[2*DATA_WIDTH-1:0];
    assign bus.user_rd_last  = head_o[2*DATA_WIDTH];
    assign bus.user_rd_valid = head_valid_o;
    assign bus.fifo_count    = count_o;
    assign bus.rd_cmd_allow  = rd_cmd_allow_q;
    assign bus.overflow      = overflow_q;

endmodule

// File: tb/tb_ddr2_rd_user_fifo.sv
// Scoreboard bench for ddr2_rd_user_fifo: a small behavioural model predicts
// accepted words, occupancy, credit and overflow; a monitor checks every pop.
module tb_ddr2_rd_user_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int BB    = 2;

    logic clk;
    logic reset;

    ddr2_rd_user_fifo_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

    ddr2_rd_user_fifo #(
        .DATA_WIDTH  (DW),
        .FIFO_DEPTH  (DEPTH),
        .BURST_BEATS (BB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [2*DW:0] sb [$];

    bit m_run;
    int m_beat;
    int m_count;
    bit m_ovf;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Every handshake seen on the user side must match the oldest expected word.
    always @(negedge clk) begin
        logic [2*DW:0] e;
        if (!reset && bus.user_rd_valid && bus.user_rd_ready) begin
            if (sb.size() == 0) begin
                chk("sb_size", 128'(sb.size()), 1);
            end else begin
                e = sb.pop_front();
                chk("pop_data", bus.user_rd_data, e[2*DW-1:0]);
                chk("pop_last", bus.user_rd_last, e[2*DW]);
            end
        end
    end

    // One clock of stimulus; the model is advanced with the inputs of that edge.
    task automatic cycle(input logic v, input logic [DW-1:0] r, input logic [DW-1:0] f);
        bit pop, acc, lst;
        bus.read_data_valid     = v;
        bus.read_data_fifo_rise = r;
        bus.read_data_fifo_fall = f;
        pop = (m_count > 0) && bus.user_rd_ready;
        acc = 1'b0;
        if (m_run && v) begin
            lst = (m_beat == BB - 1);
            acc = (m_count < DEPTH) || pop;
            if (acc) sb.push_back({lst, f, r});
            else     m_ovf = 1'b1;
            m_beat = lst ? 0 : m_beat + 1;
        end
        m_count = m_count + int'(acc) - int'(pop);
        if (!m_run && bus.comp_done) begin
            m_run  = 1'b1;
            m_beat = 0;
        end else if (m_run && !bus.comp_done) begin
            m_run  = 1'b0;
            m_beat = 0;
        end
        @(posedge clk);
        #1;
        bus.read_data_valid = 1'b0;
        chk("count", bus.fifo_count, 128'(m_count));
        chk("allow", bus.rd_cmd_allow, m_run && (DEPTH - m_count >= 2 * BB));
        chk("ovf", bus.overflow, m_ovf);
        chk("valid", bus.user_rd_valid, m_count > 0);
    endtask

    task automatic do_reset();
        bus.user_rd_ready   = 1'b0;
        bus.read_data_valid = 1'b0;
        bus.comp_done       = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_valid", bus.user_rd_valid, 0);
        chk("rst_data", bus.user_rd_data, 0);
        chk("rst_last", bus.user_rd_last, 0);
        chk("rst_count", bus.fifo_count, 0);
        chk("rst_allow", bus.rd_cmd_allow, 0);
        chk("rst_ovf", bus.overflow, 0);
        sb.delete();
        m_run   = 1'b0;
        m_beat  = 0;
        m_count = 0;
        m_ovf   = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic calibrate();
        bus.comp_done = 1'b1;
        cycle(1'b0, '0, '0);
    endtask

    task automatic drain();
        bus.user_rd_ready = 1'b1;
        for (int i = 0; i < 40 && m_count > 0; i++) cycle(1'b0, '0, '0);
        chk("drained", bus.fifo_count, 0);
        chk("sb_drained", 128'(sb.size()), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        reset                   = 1'b1;
        bus.comp_done           = 1'b0;
        bus.read_data_valid     = 1'b0;
        bus.read_data_fifo_rise = '0;
        bus.read_data_fifo_fall = '0;
        bus.user_rd_ready       = 1'b0;
        do_reset();

        // Calibration gating: beats before comp_done are discarded.
        bus.user_rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'hA5A50000 + i, 32'h5A5A0000 + i);
        chk("gate_count", bus.fifo_count, 0);
        chk("gate_ovf", bus.overflow, 0);

        // The beat on the calibration-exit edge is still discarded.
        bus.comp_done = 1'b1;
        cycle(1'b1, 32'hDEADDEAD, 32'hBEEFBEEF);
        chk("exit_count", bus.fifo_count, 0);

        // Packing and one-cycle latency.
        cycle(1'b1, 32'h11111111, 32'h22222222);
        chk("pk0_data", bus.user_rd_data, 64'h2222222211111111);
        chk("pk0_last", bus.user_rd_last, 0);
        cycle(1'b1, 32'h33333333, 32'h44444444);
        chk("pk1_data", bus.user_rd_data, 64'h4444444433333333);
        chk("pk1_last", bus.user_rd_last, 1);
        drain();

        // Backpressure: 17 beats into a 16-deep FIFO.
        do_reset();
        calibrate();
        bus.user_rd_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            cycle(1'b1, 32'h1000 + i, ~(32'h1000 + i));
            if (i == 11) chk("allow_at12", bus.rd_cmd_allow, 1);
            if (i == 12) chk("allow_at13", bus.rd_cmd_allow, 0);
        end
        chk("full_count", bus.fifo_count, 16);
        chk("full_ovf", bus.overflow, 1);
        cycle(1'b0, '0, '0);
        chk("hold_data", bus.user_rd_data, sb[0][2*DW-1:0]);
        chk("hold_last", bus.user_rd_last, sb[0][2*DW]);
        bus.user_rd_ready = 1'b1;
        cycle(1'b1, 32'h2000, 32'h3000);
        chk("after_drop_count", bus.fifo_count, 16);
        drain();
        chk("ovf_sticky", bus.overflow, 1);

        // Simultaneous push and pop on a full FIFO without any drop.
        do_reset();
        calibrate();
        for (int i = 0; i < 16; i++) cycle(1'b1, 32'h4000 + i, 32'h5000 + i);
        chk("sp_full", bus.fifo_count, 16);
        bus.user_rd_ready = 1'b1;
        cycle(1'b1, 32'h6000, 32'h7000);
        chk("sp_count", bus.fifo_count, 16);
        chk("sp_ovf", bus.overflow, 0);
        drain();

        // Recalibration mid-burst: queued words drain, new beats are discarded.
        do_reset();
        calibrate();
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'h8000 + i, 32'h9000 + i);
        bus.comp_done = 1'b0;
        cycle(1'b0, '0, '0);
        cycle(1'b1, 32'hBAD0, 32'hBAD1);
        cycle(1'b1, 32'hBAD2, 32'hBAD3);
        chk("recal_count", bus.fifo_count, 5);
        bus.user_rd_ready = 1'b1;
        cycle(1'b1, 32'hBAD4, 32'hBAD5);
        drain();
        calibrate();
        bus.user_rd_ready = 1'b0;
        cycle(1'b1, 32'hC000, 32'hD000);
        chk("recal_last0", bus.user_rd_last, 0);
        cycle(1'b1, 32'hC001, 32'hD001);
        drain();

        // Asynchronous reset with nine words queued.
        bus.user_rd_ready = 1'b0;
        for (int i = 0; i < 9; i++) cycle(1'b1, 32'hE000 + i, 32'hF000 + i);
        chk("pre_rst_count", bus.fifo_count, 9);
        do_reset();

        chk("sb_left", 128'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ddr2_rd_user_fifo.md
# ddr2_rd_user_fifo

Downstream stage of the DDR2 read-data path. Captures the calibrated rise/fall read beats from the read-data block only after pattern calibration completes, and packs each beat pair into one user word. Words are buffered in a first-word-fall-through FIFO with a valid/ready handshake and a per-burst `last` tag. The block also produces a read-command credit signal back to the controller so reads are only issued when a whole burst fits.

## Interface
- `DATA_WIDTH`, 32: width of each rise/fall half (matches `` `DATA_WIDTH ``).
- `FIFO_DEPTH`, 16: number of packed entries; power of two, ≥ 2*`BURST_BEATS`.
- `BURST_BEATS`, 2: clock beats per read burst (BL4 = 2).

Ports:
- `clk` in 1: sole clock. All logic is on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `comp_done` in 1: calibration complete from the read-data block.
- `read_data_valid` in 1: qualifies the rise/fall data this cycle.
- `read_data_fifo_rise` in `DATA_WIDTH`: rise-edge data.
- `read_data_fifo_fall` in `DATA_WIDTH`: fall-edge data.
- `user_rd_data` out 2*`DATA_WIDTH`: packed word `{fall, rise}`, with rise in the low half.
- `user_rd_valid` out 1: FIFO head is valid.
- `user_rd_ready` in 1: user accepts the head word.
- `user_rd_last` out 1: head word is the final beat of its burst.
- `fifo_count` out log2(`FIFO_DEPTH`)+1: current occupancy.
- `rd_cmd_allow` out 1: controller may issue one read burst.
- `overflow` out 1: sticky; set when a beat was dropped.

## Operation
- **States:** `WAIT_CAL` and `RUN`. Reset enters `WAIT_CAL`.
- **`WAIT_CAL`:**
  - Every valid beat is discarded; these are calibration pattern reads.
  - The beat counter is held at 0.
  - When `comp_done` is 1, go to `RUN` next cycle.
- **`RUN`:**
  - Each `read_data_valid` beat is a push of `{fall, rise}` plus a last bit.
  - last = (beat_cnt == `BURST_BEATS`-1).
  - beat_cnt increments on every valid beat, wrapping to 0 after `BURST_BEATS`-1.
  - When `comp_done` falls (recalibration): go to `WAIT_CAL` and clear beat_cnt. FIFO contents are kept and continue to drain.
- **Pop:** occurs when `user_rd_valid` && `user_rd_ready`.
- **Push rules:**
  - A push is accepted if count < `FIFO_DEPTH`, or if a pop happens in the same cycle.
  - Otherwise the beat is dropped and `overflow` is set to 1.
  - beat_cnt still advances on a dropped beat, to preserve burst alignment.
- **Empty + push:** the word is not bypassed combinationally; it appears in the next cycle.
- **Count update per cycle:** count' = count + push_accepted − pop. Simultaneous push and pop leaves the count unchanged.
- **Pointers:** wrap modulo `FIFO_DEPTH`.
- **`rd_cmd_allow`:** registered; equals (state==`RUN`) && (`FIFO_DEPTH` − count' ≥ 2*`BURST_BEATS`).
- **`overflow`:** cleared only by `reset`.

## Timing
- **Reset values:**
  - `user_rd_valid`=0, `user_rd_last`=0, `user_rd_data`=0.
  - `fifo_count`=0, `rd_cmd_allow`=0, `overflow`=0.
  - State = `WAIT_CAL`, pointers = 0.
- **Latency:**
  - A beat sampled at edge N gives `user_rd_valid`=1 with that data after edge N.
  - One cycle from `read_data_valid` to `user_rd_valid`.
- **Calibration exit:** `comp_done` rising before edge N → `RUN` after edge N. The first beat that can be accepted is the one sampled at edge N+1.
- **Handshake:** while `user_rd_valid`=1 and `user_rd_ready`=0, `user_rd_data` and `user_rd_last` are held stable.
- **Outputs:** `fifo_count` and `rd_cmd_allow` are registered and reflect the post-edge occupancy.
- **Reset mid-operation:** all entries are discarded immediately (asynchronous) and outputs take their reset values.

## Structure
- **Package `ddr2_rd_pkg`:**
  - state enum (`WAIT_CAL`, `RUN`);
  - count-width function clog2(depth)+1;
  - default constants `DATA_WIDTH`=32 and `BURST_BEATS`=2.
- **Sub-module `ddr2_sync_fifo`:**
  - generic first-word-fall-through storage, pointers and count;
  - width 2*`DATA_WIDTH`+1, where the extra bit is the last tag.
- **Top level:** state machine, beat counter, drop/overflow logic and credit generation.

## Test plan
- Calibration gating: `comp_done`=0, 4 valid beats → `fifo_count` stays 0 and `overflow`=0.
- Packing:
  - Setup: `comp_done`=1, `user_rd_ready`=1.
  - Stimulus: beats rise/fall = 0x11111111/0x22222222, then 0x33333333/0x44444444.
  - Response: `user_rd_data`=0x2222222211111111 with last=0, then 0x4444444433333333 with last=1, each one cycle after its beat.
- Backpressure and full:
  - Setup: `user_rd_ready`=0.
  - Stimulus: 17 beats.
  - Response: `fifo_count`=16 and `overflow`=1. `rd_cmd_allow` drops once count reaches 13, and last tags stay aligned after the drop.
- Simultaneous push and pop: FIFO full, `user_rd_ready`=1 with a valid beat → beat accepted, count stays 16, `overflow` stays 0.
- Recalibration: `comp_done` drops mid-burst with 5 words queued → all 5 drain correctly, new beats are discarded, beat_cnt restarts at 0 when `comp_done` returns.
- Asynchronous reset: assert `reset` between edges with count=9 → outputs are 0 and count=0 immediately, without waiting for a clock edge.
